// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, flags, shifts and a shift-add multiplier.
// Define ALU_SEQ_DIV_EN to add an unsigned restoring divider on op 1110.
module alu_seq #(
   parameter int WIDTH = 8,
   localparam int CNTW = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_v,
   output logic               flag_n,
   output logic               err
);

   localparam logic [3:0] OP_ZERO = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_NOTA = 4'b0101;
   localparam logic [3:0] OP_NOTB = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_MAX  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;
   localparam logic [3:0] OP_SHL  = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_DIV  = 4'b1110;

   localparam logic [CNTW-1:0] W_CNT = CNTW'(WIDTH);
   localparam logic [CNTW-1:0] LAST  = CNTW'(WIDTH - 1);

`ifdef ALU_SEQ_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

   state_t state;
   logic [CNTW-1:0] cnt;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc_nx;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     dif;
   logic [CNTW-1:0]    sh;
   logic [WIDTH-1:0]   shl;
   logic [WIDTH-1:0]   shr;
   logic [2*WIDTH-1:0] alu_res;
   logic               alu_c;
   logic               alu_v;
   logic               alu_n;
   logic               alu_err;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);

   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};
   assign sh  = b[CNTW-1:0];
   assign shl = (sh >= W_CNT) ? '0 : a << sh;
   assign shr = (sh >= W_CNT) ? '0 : a >> sh;

   assign acc_nx = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic             q_bit;
   logic             unused_rem;

   // restoring step: shift in next dividend bit, subtract when it fits
   assign rem_sh     = {rem, quo[WIDTH-1]};
   assign q_bit      = rem_sh >= {1'b0, dvsr};
   assign rem_nx     = q_bit ? rem_sh - {1'b0, dvsr} : rem_sh;
   assign quo_nx     = {quo[WIDTH-2:0], q_bit};
   assign unused_rem = rem_nx[WIDTH];
`endif

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      unique case (op)
         OP_ZERO: alu_res = '0;
         OP_ADD: begin
            alu_res[WIDTH:0] = sum;
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res[WIDTH:0] = dif;
            alu_c = dif[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res[WIDTH-1:0] = a & b;
         OP_OR:   alu_res[WIDTH-1:0] = a | b;
         OP_NOTA: alu_res[WIDTH-1:0] = ~a;
         OP_NOTB: alu_res[WIDTH-1:0] = ~b;
         OP_XOR:  alu_res[WIDTH-1:0] = a ^ b;
         OP_NOR:  alu_res[WIDTH-1:0] = ~(a | b);
         OP_XNOR: alu_res[WIDTH-1:0] = ~(a ^ b);
         OP_MAX:  alu_res[WIDTH-1:0] = (a >= b) ? a : b;
         OP_MUL:  alu_res = '0;
         OP_SHL:  alu_res[WIDTH-1:0] = shl;
         OP_SHR:  alu_res[WIDTH-1:0] = shr;
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            // only the divide-by-zero case completes in one cycle
            alu_res = {a, {WIDTH{1'b1}}};
            alu_err = 1'b1;
         end
`endif
         default: alu_err = 1'b1;
      endcase
      alu_n = (op == OP_DIV) ? alu_res[2*WIDTH-1] : alu_res[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         result    <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
         flag_n    <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (out_valid && out_ready) out_valid <= 1'b0;
               if (in_valid && in_ready) begin
                  if (op == OP_MUL) begin
                     state     <= MUL;
                     acc       <= '0;
                     mcand     <= {{WIDTH{1'b0}}, a};
                     mplier    <= b;
                     cnt       <= '0;
                     out_valid <= 1'b0;
                  end
`ifdef ALU_SEQ_DIV_EN
                  else if (op == OP_DIV && b != '0) begin
                     state     <= DIV;
                     rem       <= '0;
                     quo       <= a;
                     dvsr      <= b;
                     cnt       <= '0;
                     out_valid <= 1'b0;
                  end
`endif
                  else begin
                     result    <= alu_res;
                     flag_z    <= (alu_res == '0);
                     flag_c    <= alu_c;
                     flag_v    <= alu_v;
                     flag_n    <= alu_n;
                     err       <= alu_err;
                     out_valid <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc    <= acc_nx;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNTW'(1);
               if (cnt == LAST) begin
                  state     <= IDLE;
                  result    <= acc_nx;
                  flag_z    <= (acc_nx == '0);
                  flag_c    <= 1'b0;
                  flag_v    <= 1'b0;
                  flag_n    <= acc_nx[2*WIDTH-1];
                  err       <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
`ifdef ALU_SEQ_DIV_EN
            DIV: begin
               rem <= rem_nx[WIDTH-1:0];
               quo <= quo_nx;
               cnt <= cnt + CNTW'(1);
               if (cnt == LAST) begin
                  state     <= IDLE;
                  result    <= {rem_nx[WIDTH-1:0], quo_nx};
                  flag_z    <= ({rem_nx[WIDTH-1:0], quo_nx} == '0);
                  flag_c    <= 1'b0;
                  flag_v    <= 1'b0;
                  flag_n    <= rem_nx[WIDTH-1];
                  err       <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8), directed vectors plus random ops.
// Build with +define+ALU_SEQ_DIV_EN to exercise the divider.
module tb_alu_seq;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [3:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;
   logic           flag_z;
   logic           flag_c;
   logic           flag_v;
   logic           flag_n;
   logic           err;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
      .flag_z(flag_z), .flag_c(flag_c),
      .flag_v(flag_v), .flag_n(flag_n),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic z, c, v, n, e;
      int lat;
      int stamp;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int fails = 0;
   int negcnt = 0;
   bit lat_done = 0;
   bit rand_rdy = 0;

   function automatic exp_t mk(int r, bit z, bit c, bit v, bit n, bit e, int lat);
      exp_t x;
      x.res = 16'(r);
      x.z = z; x.c = c; x.v = v; x.n = n; x.e = e;
      x.lat = lat;
      x.stamp = 0;
      return x;
   endfunction

   // arithmetic reference derived from the opcode table, not from the datapath
   function automatic exp_t model(logic [3:0] o, logic [7:0] x, logic [7:0] y);
      exp_t e;
      int ua, ub, sa, sbv, s, r, shamt;
      ua = int'(x);
      ub = int'(y);
      sa = (ua >= 128) ? ua - 256 : ua;
      sbv = (ub >= 128) ? ub - 256 : ub;
      shamt = ub % 16;
      r = 0;
      e = mk(0, 0, 0, 0, 0, 0, 1);
      case (o)
         4'd0: r = 0;
         4'd1: begin
            r = ua + ub;
            e.c = (r >= 256);
            s = sa + sbv;
            e.v = (s > 127) || (s < -128);
         end
         4'd2: begin
            r = (ua - ub + 256) % 256 + ((ua < ub) ? 256 : 0);
            e.c = (ua < ub);
            s = sa - sbv;
            e.v = (s > 127) || (s < -128);
         end
         4'd3: r = ua & ub;
         4'd4: r = ua | ub;
         4'd5: r = 255 - ua;
         4'd6: r = 255 - ub;
         4'd7: r = ua ^ ub;
         4'd8: r = 255 - (ua | ub);
         4'd9: r = 255 - (ua ^ ub);
         4'd10: r = (ua >= ub) ? ua : ub;
         4'd11: begin
            r = ua * ub;
            e.lat = W + 1;
         end
         4'd12: r = (shamt >= 8) ? 0 : (ua << shamt) % 256;
         4'd13: r = (shamt >= 8) ? 0 : ua >> shamt;
`ifdef ALU_SEQ_DIV_EN
         4'd14: begin
            if (ub == 0) begin
               r = ua * 256 + 255;
               e.e = 1;
            end else begin
               r = (ua % ub) * 256 + ua / ub;
               e.lat = W + 1;
            end
         end
`endif
         default: e.e = 1;
      endcase
      e.res = 16'(r);
      e.z = (r == 0);
      e.n = (o == 4'd11 || o == 4'd14) ? e.res[15] : e.res[7];
      return e;
   endfunction

   // monitor: latency on first sight of out_valid, contents on transfer
   always @(negedge clk) begin
      exp_t e;
      int lat;
      negcnt++;
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            if (fails < 40)
               $display("FAIL unexpected_out: result=%h with no pending op", result);
         end else begin
            if (!lat_done) begin
               lat = negcnt - sb[0].stamp;
               checks++;
               if (lat != sb[0].lat) begin
                  fails++;
                  $display("FAIL latency: got %0d expected %0d", lat, sb[0].lat);
               end
               lat_done = 1;
            end
            if (out_ready) begin
               e = sb.pop_front();
               lat_done = 0;
               checks++;
               if ({result, flag_z, flag_c, flag_v, flag_n, err} !==
                   {e.res, e.z, e.c, e.v, e.n, e.e}) begin
                  fails++;
                  $display("FAIL result: got %h zcvn=%b%b%b%b err=%b expected %h zcvn=%b%b%b%b err=%b",
                           result, flag_z, flag_c, flag_v, flag_n, err,
                           e.res, e.z, e.c, e.v, e.n, e.e);
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic issue(input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input exp_t e, input bit push);
      bit ok;
      bit rdy;
      ok = 0;
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) ok = 1;
      end
      if (!ok) begin
         checks++;
         fails++;
         $display("FAIL accept_timeout: op=%h never accepted", o);
      end else if (push) begin
         e.stamp = negcnt;
         sb.push_back(e);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      int bad;
      logic [3:0] ro;
      logic [7:0] ra;
      logic [7:0] rb;

      rst = 1'b1;
      in_valid = 1'b0;
      op = '0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, result, flag_z, flag_c, flag_v, flag_n, err, in_ready} !==
          {1'b0, 16'h0, 5'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_state: ov=%b res=%h flags=%b%b%b%b err=%b rdy=%b expected 0/0000/0000/0/1",
                  out_valid, result, flag_z, flag_c, flag_v, flag_n, err, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // directed single-cycle vectors, back to back
      t0 = negcnt;
      issue(4'h1, 8'h6B, 8'hAA, mk(16'h0115, 0, 1, 0, 0, 0, 1), 1);
      issue(4'h2, 8'h6B, 8'hAA, mk(16'h01C1, 0, 1, 1, 1, 0, 1), 1);
      issue(4'h3, 8'hF0, 8'h3C, mk(16'h0030, 0, 0, 0, 0, 0, 1), 1);
      issue(4'h7, 8'hFF, 8'h0F, mk(16'h00F0, 0, 0, 0, 1, 0, 1), 1);
      issue(4'h5, 8'h0F, 8'h00, mk(16'h00F0, 0, 0, 0, 1, 0, 1), 1);
      issue(4'hA, 8'h05, 8'h09, mk(16'h0009, 0, 0, 0, 0, 0, 1), 1);
      issue(4'hA, 8'hA0, 8'h50, mk(16'h00A0, 0, 0, 0, 1, 0, 1), 1);
      issue(4'hC, 8'h81, 8'h13, mk(16'h0008, 0, 0, 0, 0, 0, 1), 1);
      issue(4'hD, 8'h81, 8'h03, mk(16'h0010, 0, 0, 0, 0, 0, 1), 1);
      issue(4'hC, 8'h81, 8'h08, mk(16'h0000, 1, 0, 0, 0, 0, 1), 1);
      issue(4'h0, 8'hFF, 8'hFF, mk(16'h0000, 1, 0, 0, 0, 0, 1), 1);
      issue(4'hF, 8'h12, 8'h34, mk(16'h0000, 1, 0, 0, 0, 1, 1), 1);
      issue(4'h8, 8'h0F, 8'hF0, mk(16'h0000, 1, 0, 0, 0, 0, 1), 1);
      issue(4'h2, 8'h55, 8'h55, mk(16'h0000, 1, 0, 0, 0, 0, 1), 1);
      issue(4'h1, 8'h7F, 8'h01, mk(16'h0080, 0, 0, 1, 1, 0, 1), 1);
      checks++;
      if (negcnt - t0 != 15) begin
         fails++;
         $display("FAIL back_to_back: took %0d cycles expected 15", negcnt - t0);
      end
      drain();

`ifdef ALU_SEQ_DIV_EN
      issue(4'hE, 8'hAA, 8'h06, mk(16'h021C, 0, 0, 0, 0, 0, W + 1), 1);
      issue(4'hE, 8'hAA, 8'h00, mk(16'hAAFF, 0, 0, 0, 1, 1, 1), 1);
`else
      issue(4'hE, 8'hAA, 8'h06, mk(16'h0000, 1, 0, 0, 0, 1, 1), 1);
`endif
      drain();

      // multiply: in_ready low for the whole iteration
      issue(4'hB, 8'h6B, 8'hAA, mk(16'h470E, 0, 0, 0, 0, 0, W + 1), 1);
      bad = 0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL mul_busy: in_ready high in %0d of %0d cycles, expected 0", bad, W);
      end
      @(posedge clk);
      #1;
      drain();

      // backpressure hold
      out_ready = 1'b0;
      issue(4'h1, 8'h6B, 8'hAA, mk(16'h0115, 0, 1, 0, 0, 0, 1), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, result, flag_c, in_ready} !== {1'b1, 16'h0115, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL hold: ov=%b res=%h c=%b rdy=%b expected 1/0115/1/0",
                     out_valid, result, flag_c, in_ready);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL release_ready: in_ready=%b expected 1", in_ready);
      end
      @(posedge clk);
      #1;
      drain();

      // reset during the multiply aborts it
      issue(4'hB, 8'h6B, 8'hAA, mk(0, 0, 0, 0, 0, 0, 0), 0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, result, in_ready} !== {1'b0, 16'h0, 1'b1}) begin
         fails++;
         $display("FAIL mid_reset: ov=%b res=%h rdy=%b expected 0/0000/1",
                  out_valid, result, in_ready);
      end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL stale_after_reset: out_valid high %0d cycles expected 0", bad);
      end
      @(posedge clk);
      #1;

      // random ops with random consumer stalls
      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         case ($urandom_range(0, 3))
            0: rb = 8'($urandom_range(0, 15));
            1: rb = 8'h00;
            default: rb = 8'($urandom);
         endcase
         issue(ro, ra, rb, model(ro, ra, rb), 1);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_rdy = 0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
